// File: rtl/mini_mips_ctrl_pkg.sv
// Shared encodings for the MiniMIPS multi-cycle main control unit:
// opcodes, FSM state codes, and the datapath mux/ALU select codes.
package mini_mips_ctrl_pkg;

   localparam logic [3:0] OP_RTYPE = 4'd0;
   localparam logic [3:0] OP_ADDI  = 4'd1;
   localparam logic [3:0] OP_LW    = 4'd2;
   localparam logic [3:0] OP_SW    = 4'd3;
   localparam logic [3:0] OP_BEQ   = 4'd4;
   localparam logic [3:0] OP_BNE   = 4'd5;
   localparam logic [3:0] OP_J     = 4'd6;

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_MEMADR = 4'd2,
      S_MEMRD  = 4'd3,
      S_MEMWB  = 4'd4,
      S_MEMWR  = 4'd5,
      S_EXEC   = 4'd6,
      S_RWB    = 4'd7,
      S_BRANCH = 4'd8,
      S_JUMP   = 4'd9,
      S_IEXEC  = 4'd10,
      S_IWB    = 4'd11
   } state_t;

   localparam logic [1:0] ALUOP_ADD  = 2'b00;
   localparam logic [1:0] ALUOP_SUB  = 2'b01;
   localparam logic [1:0] ALUOP_FUNC = 2'b10;

   localparam logic [1:0] SRCB_REG = 2'b00;
   localparam logic [1:0] SRCB_ONE = 2'b01;
   localparam logic [1:0] SRCB_IMM = 2'b10;
   localparam logic [1:0] SRCB_BR  = 2'b11;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   function automatic logic is_legal_op(input logic [3:0] op);
      return op <= OP_J;
   endfunction

endpackage

// File: rtl/mini_mips_control_fsm.sv
// Multi-cycle main control FSM for MiniMIPS: sequences the datapath,
// drives alu_op toward the ALU control decoder, and counts retired instructions.
//
//  state  | meaning
//  FETCH  | read instruction at PC, PC+1 -> PC when memory completes
//  DECODE | read registers, precompute branch target into ALUOut
//  MEMADR | compute load/store address
//  MEMRD  | load data read, waits for mem_ready
//  MEMWB  | write MDR to rt
//  MEMWR  | store data write, waits for mem_ready
//  EXEC   | R-type ALU operation (func-decoded)
//  RWB    | write ALUOut to rd
//  BRANCH | compare regA/regB, conditional PC load from ALUOut
//  JUMP   | PC <- jump target
//  IEXEC  | ADDI ALU operation
//  IWB    | write ALUOut to rt
module mini_mips_control_fsm
   import mini_mips_ctrl_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [3:0]       opcode,
   input  logic             mem_ready,
   output logic             pc_write,
   output logic             pc_write_cond,
   output logic             pc_write_neg,
   output logic             iord,
   output logic             mem_read,
   output logic             mem_write,
   output logic             ir_write,
   output logic             reg_write,
   output logic             reg_dst,
   output logic             mem_to_reg,
   output logic             alu_src_a,
   output logic [1:0]       alu_src_b,
   output logic [1:0]       pc_source,
   output logic [1:0]       alu_op,
   output logic             illegal_op,
   output logic [3:0]       state_o,
   output logic [CNT_W-1:0] instr_count
);

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   state_t           r_state;
   state_t           w_next;
   logic [CNT_W-1:0] r_count;
   logic             w_retire;

   logic             w_pc_write, w_pc_write_cond, w_pc_write_neg;
   logic             w_mem_read, w_mem_write, w_ir_write, w_reg_write;
   logic             w_illegal;

   always_comb begin
      w_next          = S_FETCH;
      w_retire        = 1'b0;
      w_pc_write      = 1'b0;
      w_pc_write_cond = 1'b0;
      w_pc_write_neg  = 1'b0;
      w_mem_read      = 1'b0;
      w_mem_write     = 1'b0;
      w_ir_write      = 1'b0;
      w_reg_write     = 1'b0;
      w_illegal       = 1'b0;
      iord            = 1'b0;
      reg_dst         = 1'b0;
      mem_to_reg      = 1'b0;
      alu_src_a       = 1'b0;
      alu_src_b       = SRCB_REG;
      pc_source       = PCSRC_ALU;
      alu_op          = ALUOP_ADD;
      case (r_state)
         S_FETCH: begin
            w_mem_read = 1'b1;
            alu_src_b  = SRCB_ONE;
            w_ir_write = mem_ready;
            w_pc_write = mem_ready;
            w_next     = mem_ready ? S_DECODE : S_FETCH;
         end
         S_DECODE: begin
            alu_src_b = SRCB_BR;
            w_illegal = !is_legal_op(opcode);
            case (opcode)
               OP_RTYPE:     w_next = S_EXEC;
               OP_ADDI:      w_next = S_IEXEC;
               OP_LW, OP_SW: w_next = S_MEMADR;
               OP_BEQ, OP_BNE: w_next = S_BRANCH;
               OP_J:         w_next = S_JUMP;
               default:      w_next = S_FETCH;
            endcase
         end
         S_MEMADR: begin
            alu_src_a = 1'b1;
            alu_src_b = SRCB_IMM;
            w_next    = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
         end
         S_MEMRD: begin
            w_mem_read = 1'b1;
            iord       = 1'b1;
            w_next     = mem_ready ? S_MEMWB : S_MEMRD;
         end
         S_MEMWB: begin
            w_reg_write = 1'b1;
            mem_to_reg  = 1'b1;
            w_retire    = 1'b1;
         end
         S_MEMWR: begin
            w_mem_write = 1'b1;
            iord        = 1'b1;
            w_next      = mem_ready ? S_FETCH : S_MEMWR;
            w_retire    = mem_ready;
         end
         S_EXEC: begin
            alu_src_a = 1'b1;
            alu_op    = ALUOP_FUNC;
            w_next    = S_RWB;
         end
         S_RWB: begin
            w_reg_write = 1'b1;
            reg_dst     = 1'b1;
            w_retire    = 1'b1;
         end
         S_BRANCH: begin
            alu_src_a       = 1'b1;
            alu_op          = ALUOP_SUB;
            pc_source       = PCSRC_ALUOUT;
            w_pc_write_cond = (opcode == OP_BEQ);
            w_pc_write_neg  = (opcode == OP_BNE);
            w_retire        = 1'b1;
         end
         S_JUMP: begin
            w_pc_write = 1'b1;
            pc_source  = PCSRC_JUMP;
            w_retire   = 1'b1;
         end
         S_IEXEC: begin
            alu_src_a = 1'b1;
            alu_src_b = SRCB_IMM;
            w_next    = S_IWB;
         end
         S_IWB: begin
            w_reg_write = 1'b1;
            w_retire    = 1'b1;
         end
         default: w_next = S_FETCH;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_FETCH;
         r_count <= '0;
      end else begin
         r_state <= w_next;
         if (w_retire) r_count <= r_count + CNT_ONE;
      end
   end

   // Reset masks every side-effecting output so an aborted access writes nothing.
   assign pc_write      = w_pc_write      & ~rst;
   assign pc_write_cond = w_pc_write_cond & ~rst;
   assign pc_write_neg  = w_pc_write_neg  & ~rst;
   assign mem_read      = w_mem_read      & ~rst;
   assign mem_write     = w_mem_write     & ~rst;
   assign ir_write      = w_ir_write      & ~rst;
   assign reg_write     = w_reg_write     & ~rst;
   assign illegal_op    = w_illegal       & ~rst;
   assign state_o       = r_state;
   assign instr_count   = r_count;

endmodule

// File: doc/mini_mips_control_fsm.md
Name: mini_mips_control_fsm

Overview:
- Multi-cycle main control unit for the MiniMIPS datapath; sits directly upstream of the ALU control decoder.
- Decodes the 4-bit opcode held in the instruction register.
- Sequences fetch/decode/execute/memory/writeback, producing datapath enables plus the 2-bit alu_op consumed by the ALU control decoder (together with the 3-bit func field).
- Supports a variable-latency memory through a mem_ready handshake, and counts retired instructions.

Parameters:
- CNT_W, 16, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- opcode  in  4  IR[15:12]; stable from DECODE until return to FETCH.
- mem_ready  in  1  memory completes the current access this cycle.
- pc_write  out  1  unconditional PC load.
- pc_write_cond  out  1  PC load if ALU zero (BEQ).
- pc_write_neg  out  1  PC load if ALU not zero (BNE).
- iord  out  1  memory address source: 0=PC, 1=ALUOut.
- mem_read  out  1  memory read request.
- mem_write  out  1  memory write request.
- ir_write  out  1  load IR.
- reg_write  out  1  register file write.
- reg_dst  out  1  destination register: 0=rt, 1=rd.
- mem_to_reg  out  1  writeback data: 0=ALUOut, 1=MDR.
- alu_src_a  out  1  ALU A input: 0=PC, 1=regA.
- alu_src_b  out  2  ALU B input: 00=regB, 01=const 1, 10=sign-ext imm, 11=sign-ext imm (branch target).
- pc_source  out  2  PC source: 00=ALU result, 01=ALUOut, 10=jump target.
- alu_op  out  2  00=add-class fixed op; 01=compare/subtract fixed op; 10=R-type, func-decoded; 11 is never driven.
- illegal_op  out  1  one-cycle flag, asserted in DECODE for an unrecognised opcode.
- state_o  out  4  current state encoding (debug).
- instr_count  out  CNT_W  retired instructions.

Behaviour:
- Opcodes: 0=R-type, 1=ADDI, 2=LW, 3=SW, 4=BEQ, 5=BNE, 6=J, 7..15=illegal.
- State register updates on the rising edge of clk. Outputs are Moore, decoded combinationally from the state, except the mem_ready gating noted below.
- Any output not listed for a state is 0.
- Reset: while rst is high, state=FETCH and instr_count=0. All enables (pc_write*, mem_*, ir_write, reg_write) and illegal_op are forced to 0. Asserting rst mid-instruction aborts it immediately with no writes. The first FETCH begins on the first edge after rst deasserts.
- States and encodings:
  - FETCH(0): mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00, ir_write=pc_write=mem_ready. Stays in FETCH while mem_ready=0; goes to DECODE when mem_ready=1.
  - DECODE(1): alu_src_a=0, alu_src_b=11, alu_op=00. Next state by opcode: R→EXEC, ADDI→IEXEC, LW/SW→MEMADR, BEQ/BNE→BRANCH, J→JUMP, illegal→FETCH with illegal_op=1.
  - MEMADR(2): alu_src_a=1, alu_src_b=10, alu_op=00. LW→MEMRD, SW→MEMWR.
  - MEMRD(3): mem_read=1, iord=1. Waits for mem_ready, then goes to MEMWB.
  - MEMWB(4): reg_write=1, mem_to_reg=1, reg_dst=0. Goes to FETCH.
  - MEMWR(5): mem_write=1, iord=1. Waits for mem_ready, then goes to FETCH.
  - EXEC(6): alu_src_a=1, alu_src_b=00, alu_op=10. Goes to RWB.
  - RWB(7): reg_write=1, reg_dst=1. Goes to FETCH.
  - BRANCH(8): alu_src_a=1, alu_src_b=00, alu_op=01, pc_source=01; pc_write_cond=1 for BEQ, pc_write_neg=1 for BNE. Goes to FETCH.
  - JUMP(9): pc_write=1, pc_source=10. Goes to FETCH.
  - IEXEC(10): alu_src_a=1, alu_src_b=10, alu_op=00. Goes to IWB.
  - IWB(11): reg_write=1, reg_dst=0. Goes to FETCH.
  - Encodings 12..15 are unreachable; if entered, go to FETCH on the next edge with all outputs 0.
- Cycle counts with mem_ready tied to 1:
  - R-type and ADDI: 4 cycles.
  - LW: 5 cycles.
  - SW, BEQ, BNE and J: 4, 3, 3 and 3 cycles respectively.
  - Each memory wait cycle adds 1.
- instr_count increments by 1 on every transition into FETCH from a legal completing state. It does not increment on the illegal-opcode path or on reset exit. It wraps from 2^CNT_W-1 to 0.
- mem_read and mem_write are never asserted together; mem_write is asserted only in MEMWR.

Decomposition:
- Package mini_mips_ctrl_pkg holds:
  - opcode constants;
  - the 4-bit state encoding;
  - alu_op codes (00/01/10);
  - alu_src_b and pc_source codes.
- Single module; no sub-module is warranted.

Test Plan:
- Reset: rst high mid-MEMRD → state_o=0, mem_read=0, instr_count=0 while high; after release, FETCH with mem_read=1.
- R-type: opcode 0 with mem_ready=1 → states 0,1,6,7; alu_op=10 in EXEC; reg_write=1 and reg_dst=1 in RWB; instr_count +1.
- LW with stalls: opcode 2, mem_ready=0 for 2 cycles in FETCH and 3 in MEMRD → 10 cycles total; ir_write is high exactly once and reg_write=1, mem_to_reg=1 exactly once.
- Branches: BEQ → pc_write_cond=1, pc_write_neg=0, alu_op=01 in BRANCH; BNE → pc_write_neg=1, pc_write_cond=0.
- Illegal: opcode 4'hF → illegal_op high for 1 cycle in DECODE, then FETCH; instr_count unchanged.
- Wrap: CNT_W=4, run 16 J instructions → instr_count returns to 0; pc_write=1 and pc_source=10 in each JUMP state.
